imm_encode: RTL
===============

IMM_ENCODE -- requirements
Module: imm_encode

Interface
REQ-001 The block SHALL have the parameter ERRW, default 8, which sets the width of the error counter.
REQ-002 The block SHALL have the port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have the port reset, input, 1 bit: reset is asynchronous and active-low.
REQ-004 The block SHALL have the port in_valid, input, 1 bit: the upstream request is valid.
REQ-005 The block SHALL have the port in_ready, output, 1 bit: the block accepts a request this cycle.
REQ-006 The block SHALL have the port immsrc, input, 2 bits: format select; 00 I, 01 S, 10 B, 11 J.
REQ-007 The block SHALL have the port imm, input, 32 bits: the signed immediate value to encode.
REQ-008 The block SHALL have the port base, input, 32 bits: the instruction template that supplies the non-immediate fields.
REQ-009 The block SHALL have the port out_valid, output, 1 bit: the encoded result is valid.
REQ-010 The block SHALL have the port out_ready, input, 1 bit: downstream accepts the result.
REQ-011 The block SHALL have the port instr, output, 32 bits: the encoded instruction word.
REQ-012 The block SHALL have the port err, output, 1 bit: imm is out of range or misaligned for the selected format.
REQ-013 The block SHALL have the port err_count, output, ERRW bits: a saturating count of accepted results with err=1.

Function
REQ-014 A transfer SHALL occur on a cycle where valid and ready are both 1, at the input and at the output alike; inputs are sampled only on an input transfer.
REQ-015 The block SHALL be a 2-stage pipeline: S1 registers the request and computes range and field placement; S2 registers instr, err and out_valid.
REQ-016 Latency SHALL be 2 cycles from input transfer to out_valid; with out_ready held at 1, throughput SHALL be 1 per cycle.
REQ-017 S2 SHALL load when S2 is empty or out_ready=1; S1 SHALL advance into S2 under the same condition.
REQ-018 in_ready SHALL equal (S1 empty) OR (S2 empty) OR out_ready; combinational dependence on out_ready is permitted.
REQ-019 While out_valid=1 and out_ready=0, instr and err SHALL hold stable; no result SHALL be dropped or duplicated.
REQ-020 Field placement for I: instr[31:20]=imm[11:0]; instr[19:0]=base[19:0].
REQ-021 Field placement for S: instr[31:25]=imm[11:5]; instr[11:7]=imm[4:0]; all other bits from base.
REQ-022 Field placement for B: instr[31]=imm[12]; instr[30:25]=imm[10:5]; instr[11:8]=imm[4:1]; instr[7]=imm[11]; all other bits from base.
REQ-023 Field placement for J: instr[31]=imm[20]; instr[30:21]=imm[10:1]; instr[20]=imm[11]; instr[19:12]=imm[19:12]; instr[11:0]=base[11:0].
REQ-024 Range rules: I and S require imm[31:11] to be all-equal; B requires imm[31:12] all-equal and imm[0]=0; J requires imm[31:20] all-equal and imm[0]=0.
REQ-025 On a rule violation the block SHALL set err=1 and still emit the truncated encoding.
REQ-026 err_count SHALL increment on each output transfer with err=1, and SHALL saturate at 2^ERRW-1 with no wrap.
REQ-027 For err=0, sign-extending the fields of instr back out SHALL reproduce imm exactly (round-trip property).

Reset
REQ-028 When reset is low, the block SHALL immediately clear the S1 and S2 valid bits, out_valid, err and err_count to 0, and instr to 32'h0.
REQ-029 Reset asserted mid-operation SHALL discard in-flight results; no output transfer SHALL occur in the cycle reset deasserts.
REQ-030 in_ready SHALL be 1 on the first cycle after reset deasserts.

Structure
REQ-031 A shared package SHALL hold the immsrc enum (IMM_I, IMM_S, IMM_B, IMM_J), used by this block and by the immediate extender.
REQ-032 A combinational sub-module imm_range_chk(immsrc, imm -> err) SHALL implement the range rules; pipeline registers, handshake and counter SHALL stay in imm_encode.

Verification
REQ-033 The bench SHALL cover: I, imm=32'hFFFFFFFF, base=32'h00000013 -> instr=32'hFFF00013, err=0, out_valid 2 cycles after accept.
REQ-034 The bench SHALL cover: B, imm=8, base=32'h00000063 -> instr=32'h00000463, err=0; B, imm=9 -> err=1.
REQ-035 The bench SHALL cover: J, imm=32'h00000800, base=32'h0000006F -> instr=32'h0010006F, err=0; S, imm=2048 -> err=1, err_count=1.
REQ-036 The bench SHALL cover: 4 back-to-back requests with out_ready=0 for 5 cycles, then 1 -> in_ready=0 after 2 accepts; all 4 delivered in order; instr stable while stalled.
REQ-037 The bench SHALL cover: reset pulsed low with 2 results in flight -> out_valid=0 and err_count=0 immediately; nothing emitted afterwards.
REQ-038 The bench SHALL cover: 300 err requests with ERRW=8 -> err_count=255; random legal imm -> re-extending instr equals imm.

Source files
------------

// File: rtl/imm_encode_pkg.sv
// rtl/imm_encode_pkg.sv - shared immediate-format enum and field placement helper
package imm_encode_pkg;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_J = 2'b11
  } immsrc_t;

  // Scatter the immediate into the instruction fields of the selected format;
  // bits not owned by the immediate come from the template word.
  function automatic logic [31:0] place_imm(immsrc_t src, logic [31:0] imm, logic [31:0] base);
    logic [31:0] w;
    case (src)
      IMM_I:   w = {imm[11:0], base[19:0]};
      IMM_S:   w = {imm[11:5], base[24:12], imm[4:0], base[6:0]};
      IMM_B:   w = {imm[12], imm[10:5], base[24:12], imm[4:1], imm[11], base[6:0]};
      default: w = {imm[20], imm[10:1], imm[11], imm[19:12], base[11:0]};
    endcase
    return w;
  endfunction

endpackage

// File: rtl/imm_encode_range_chk.sv
// rtl/imm_encode_range_chk.sv - range and alignment check of an immediate per format
module imm_range_chk
  import imm_encode_pkg::*;
(
  input  immsrc_t     immsrc,
  input  logic [31:0] imm,
  output logic        err
);

  logic fit12;
  logic fit13;
  logic fit21;

  // A value fits an N-bit signed field when every bit above N-2 equals the sign.
  assign fit12 = (&imm[31:11]) | ~(|imm[31:11]);
  assign fit13 = (&imm[31:12]) | ~(|imm[31:12]);
  assign fit21 = (&imm[31:20]) | ~(|imm[31:20]);

  always_comb begin
    err = 1'b0;
    case (immsrc)
      IMM_I, IMM_S: err = ~fit12;
      IMM_B:        err = ~fit13 | imm[0];
      default:      err = ~fit21 | imm[0];
    endcase
  end

endmodule

// File: rtl/imm_encode.sv
// rtl/imm_encode.sv - two-stage immediate encoder with valid/ready handshake and error counter
module imm_encode
  import imm_encode_pkg::*;
#(
  parameter int ERRW = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      immsrc,
  input  logic [31:0]     imm,
  input  logic [31:0]     base,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     instr,
  output logic            err,
  output logic [ERRW-1:0] err_count
);

  logic        s1_valid;
  immsrc_t     s1_src;
  logic [31:0] s1_imm;
  logic [31:0] s1_base;
  logic        s1_err;
  logic [31:0] s1_instr;
  logic        advance;
  logic        in_xfer;
  logic        out_xfer;

  imm_range_chk u_range_chk (
    .immsrc (s1_src),
    .imm    (s1_imm),
    .err    (s1_err)
  );

  assign s1_instr = place_imm(s1_src, s1_imm, s1_base);

  // S2 is the output register, so out_valid doubles as the S2 valid bit.
  assign advance  = ~out_valid | out_ready;
  assign in_ready = ~s1_valid | advance;
  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_src   <= IMM_I;
      s1_imm   <= 32'h0;
      s1_base  <= 32'h0;
    end else if (in_xfer) begin
      s1_valid <= 1'b1;
      s1_src   <= immsrc_t'(immsrc);
      s1_imm   <= imm;
      s1_base  <= base;
    end else if (advance) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      instr     <= 32'h0;
      err       <= 1'b0;
    end else if (advance) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        instr <= s1_instr;
        err   <= s1_err;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_count <= '0;
    end else if (out_xfer && err && (err_count != {ERRW{1'b1}})) begin
      err_count <= err_count + {{(ERRW-1){1'b0}}, 1'b1};
    end
  end

endmodule
